// File: rtl/trap_ctrl_pkg.sv
// Shared trap controller definitions: FSM encoding, CSR addresses, mcause codes.
package trap_ctrl_pkg;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_TRAP_JUMP  = 2'd1;
  localparam logic [1:0] S_RET_JUMP   = 2'd2;
  localparam logic [1:0] S_REDIR_WAIT = 2'd3;

  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MEPC  = 12'h341;

  localparam logic [63:0] MCAUSE_ECALL = 64'd11;
  localparam logic [63:0] MCAUSE_TMR   = 64'h8000_0000_0000_0007;

  typedef struct packed {
    logic tmr;
    logic ecall;
    logic mret;
  } prio_gnt_t;

  function automatic logic [63:0] align4(
    input logic [63:0] a
  );
    return {a[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Redirect handshake from the trap controller to fetch.
interface trap_ctrl_if;

  logic        redir_valid;
  logic [63:0] redir_pc;
  logic        redir_ready;

  modport master (
    output redir_valid,
    output redir_pc,
    input  redir_ready
  );

  modport slave (
    input  redir_valid,
    input  redir_pc,
    output redir_ready
  );

endinterface

// File: rtl/trap_prio.sv
// Fixed-priority trap event select: timer > ecall > mret, one-hot grant.
module trap_prio
  import trap_ctrl_pkg::*;
(
  input  logic      tmr,
  input  logic      ecall,
  input  logic      mret,
  output prio_gnt_t gnt
);

  always_comb begin
    gnt       = '0;
    gnt.tmr   = tmr;
    gnt.ecall = ecall & ~tmr;
    gnt.mret  = mret & ~tmr & ~ecall;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Commit-stage trap/return sequencer; timer trap path enabled by
// defining TRAP_CTRL_TMR_INTR_EN.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmt_valid,
  input  logic [63:0] cmt_pc,
  input  logic [63:0] cmt_npc,
  input  logic        cmt_ecall,
  input  logic        cmt_mret,
  input  logic        ex_stall,
  input  logic        tmr_pend,
  input  logic [63:0] csr_rdata,
  output logic        ecall_trap_ena,
  output logic        cmt_mret_ena,
  output logic [63:0] trap_mcause_value,
  output logic [11:0] ctl_csr_idx,
  output logic        ctl_csr_rd_en,
  output logic [63:0] ctl_wbck_data,
  output logic        tmr_ack,
  output logic        flush,
  output logic        busy,
  trap_ctrl_if.master redir
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [63:0] redir_pc_q;
  logic        jumping;
  logic        take;
  logic        tmr_req;
  prio_gnt_t   gnt;

`ifdef TRAP_CTRL_TMR_INTR_EN
  assign tmr_req = tmr_pend;
`else
  logic unused_tmr_pend;
  assign unused_tmr_pend = tmr_pend;
  assign tmr_req = 1'b0;
`endif

  assign take = (state == S_IDLE) & cmt_valid
              & ~ex_stall & ~rst;

  trap_prio u_prio (
    .tmr   (take & tmr_req),
    .ecall (take & cmt_ecall),
    .mret  (take & cmt_mret),
    .gnt   (gnt)
  );

  assign jumping = (state == S_TRAP_JUMP) |
                   (state == S_RET_JUMP);
  assign busy = (state != S_IDLE);

  // The vector/mepc read is visible to fetch in the jump cycle itself.
  assign redir.redir_pc = jumping ? align4(csr_rdata)
                                  : redir_pc_q;

  always_comb begin
    state_nxt         = state;
    ecall_trap_ena    = 1'b0;
    cmt_mret_ena      = 1'b0;
    tmr_ack           = 1'b0;
    flush             = 1'b0;
    trap_mcause_value = '0;
    ctl_wbck_data     = '0;
    ctl_csr_idx       = '0;
    ctl_csr_rd_en     = 1'b0;
    redir.redir_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        unique case (1'b1)
          gnt.tmr: begin
            tmr_ack           = 1'b1;
            flush             = 1'b1;
            trap_mcause_value = MCAUSE_TMR;
            // An interrupted ecall must re-execute.
            ctl_wbck_data = cmt_ecall ? cmt_pc
                                      : cmt_npc;
            state_nxt = S_TRAP_JUMP;
          end
          gnt.ecall: begin
            ecall_trap_ena    = 1'b1;
            flush             = 1'b1;
            trap_mcause_value = MCAUSE_ECALL;
            ctl_wbck_data     = cmt_pc;
            state_nxt         = S_TRAP_JUMP;
          end
          gnt.mret: begin
            cmt_mret_ena = 1'b1;
            flush        = 1'b1;
            state_nxt    = S_RET_JUMP;
          end
          default: state_nxt = S_IDLE;
        endcase
      end
      S_TRAP_JUMP, S_RET_JUMP: begin
        ctl_csr_idx = (state == S_TRAP_JUMP)
                    ? CSR_MTVEC : CSR_MEPC;
        ctl_csr_rd_en     = 1'b1;
        redir.redir_valid = 1'b1;
        state_nxt = redir.redir_ready ? S_IDLE
                                      : S_REDIR_WAIT;
      end
      S_REDIR_WAIT: begin
        redir.redir_valid = 1'b1;
        state_nxt = redir.redir_ready ? S_IDLE
                                      : S_REDIR_WAIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      redir_pc_q <= '0;
    end else begin
      state <= state_nxt;
      if (jumping)
        redir_pc_q <= align4(csr_rdata);
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with a cycle-level reference model.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

`ifdef TRAP_CTRL_TMR_INTR_EN
  localparam bit TMR_EN = 1'b1;
`else
  localparam bit TMR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmt_valid;
  logic [63:0] cmt_pc;
  logic [63:0] cmt_npc;
  logic        cmt_ecall;
  logic        cmt_mret;
  logic        ex_stall;
  logic        tmr_pend;
  logic [63:0] csr_rdata;
  logic        ecall_trap_ena;
  logic        cmt_mret_ena;
  logic [63:0] trap_mcause_value;
  logic [11:0] ctl_csr_idx;
  logic        ctl_csr_rd_en;
  logic [63:0] ctl_wbck_data;
  logic        tmr_ack;
  logic        flush;
  logic        busy;

  logic [63:0] mtvec;
  logic [63:0] mepc;
  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  trap_ctrl_if rif ();

  trap_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .cmt_valid         (cmt_valid),
    .cmt_pc            (cmt_pc),
    .cmt_npc           (cmt_npc),
    .cmt_ecall         (cmt_ecall),
    .cmt_mret          (cmt_mret),
    .ex_stall          (ex_stall),
    .tmr_pend          (tmr_pend),
    .csr_rdata         (csr_rdata),
    .ecall_trap_ena    (ecall_trap_ena),
    .cmt_mret_ena      (cmt_mret_ena),
    .trap_mcause_value (trap_mcause_value),
    .ctl_csr_idx       (ctl_csr_idx),
    .ctl_csr_rd_en     (ctl_csr_rd_en),
    .ctl_wbck_data     (ctl_wbck_data),
    .tmr_ack           (tmr_ack),
    .flush             (flush),
    .busy              (busy),
    .redir             (rif)
  );

  always #5 clk = ~clk;

  // CSR file stand-in; returns junk for anything it was not asked for.
  always_comb begin
    csr_rdata = 64'hdead_beef_dead_beef;
    if (ctl_csr_rd_en && ctl_csr_idx == 12'h305)
      csr_rdata = mtvec;
    else if (ctl_csr_rd_en && ctl_csr_idx == 12'h341)
      csr_rdata = mepc;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%h exp=%h",
               nm, $time, act, exp);
    end
  endtask

  // Model: busy flag, first-busy-cycle flag, CSR to read, last target.
  bit          m_busy = 1'b0;
  bit          m_read = 1'b0;
  logic [11:0] m_csr = '0;
  logic [63:0] m_pc = '0;

  always @(negedge clk) begin : model
    bit ev, t, e, r;
    logic [63:0] tgt, e_mc, e_wb, e_pc;
    if (chk_on) begin
      ev = !m_busy && !rst && cmt_valid && !ex_stall;
      t  = ev && TMR_EN && tmr_pend;
      e  = ev && !t && cmt_ecall;
      r  = ev && !t && !cmt_ecall && cmt_mret;
      e_mc = t ? 64'h8000_0000_0000_0007 :
             e ? 64'd11 : 64'd0;
      e_wb = t ? (cmt_ecall ? cmt_pc : cmt_npc) :
             e ? cmt_pc : 64'd0;
      tgt = (m_csr == 12'h305) ? mtvec : mepc;
      tgt[1:0] = 2'b00;
      e_pc = (m_busy && m_read) ? tgt : m_pc;
      chk("m_tmr_ack", tmr_ack, t);
      chk("m_ecall", ecall_trap_ena, e);
      chk("m_mret", cmt_mret_ena, r);
      chk("m_flush", flush, t | e | r);
      chk("m_mcause", trap_mcause_value, e_mc);
      chk("m_wbck", ctl_wbck_data, e_wb);
      chk("m_rd_en", ctl_csr_rd_en, m_busy && m_read);
      chk("m_idx", ctl_csr_idx,
          (m_busy && m_read) ? m_csr : 12'h0);
      chk("m_busy", busy, m_busy);
      chk("m_valid", rif.redir_valid, m_busy);
      chk("m_pc", rif.redir_pc, e_pc);
      if (rst) begin
        m_busy = 0;
        m_read = 0;
        m_pc   = '0;
      end else if (m_busy) begin
        if (m_read) m_pc = tgt;
        m_read = 0;
        if (rif.redir_ready) m_busy = 0;
      end else if (t | e | r) begin
        m_busy = 1;
        m_read = 1;
        m_csr  = r ? 12'h341 : 12'h305;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [63:0] pc,
                        input logic ec,
                        input logic mr,
                        input logic tp);
    cmt_valid = 1'b1;
    cmt_pc    = pc;
    cmt_npc   = pc + 64'd4;
    cmt_ecall = ec;
    cmt_mret  = mr;
    tmr_pend  = tp;
  endtask

  task automatic idle();
    cmt_valid = 1'b0;
    cmt_ecall = 1'b0;
    cmt_mret  = 1'b0;
    tmr_pend  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cmt_pc = '0;
    cmt_npc = '0;
    ex_stall = 1'b0;
    mtvec = 64'h8000_1003;
    mepc  = 64'h8000_0014;
    rif.redir_ready = 1'b0;
    cyc();
    chk_on = 1'b1;
    cyc();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rif.redir_valid, 0);
    chk("rst_pc", rif.redir_pc, 0);

    // ecall into mtvec, fetch ready at once
    cyc();
    rst = 1'b0;
    rif.redir_ready = 1'b1;
    commit(64'h8000_0010, 1, 0, 0);
    @(negedge clk);
    chk("ec_ena", ecall_trap_ena, 1);
    chk("ec_mcause", trap_mcause_value, 11);
    chk("ec_wbck", ctl_wbck_data, 64'h8000_0010);
    cyc();
    idle();
    @(negedge clk);
    chk("ec_redir", rif.redir_pc, 64'h8000_1000);
    chk("ec_idx", ctl_csr_idx, 12'h305);
    cyc();
    @(negedge clk);
    chk("ec_idle", busy, 0);
    chk("ec_pc_hold", rif.redir_pc, 64'h8000_1000);

    // mret with fetch back-pressure; ecalls arriving meanwhile ignored
    cyc();
    rif.redir_ready = 1'b0;
    commit(64'h200, 0, 1, 0);
    @(negedge clk);
    chk("mr_ena", cmt_mret_ena, 1);
    cyc();
    commit(64'h300, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mr_valid", rif.redir_valid, 1);
      chk("mr_pc", rif.redir_pc, 64'h8000_0014);
      cyc();
    end
    idle();
    rif.redir_ready = 1'b1;
    @(negedge clk);
    chk("mr_valid4", rif.redir_valid, 1);
    cyc();
    @(negedge clk);
    chk("mr_idle", busy, 0);

    // timer and ecall together
    cyc();
    commit(64'h100, 1, 0, 1);
    @(negedge clk);
`ifdef TRAP_CTRL_TMR_INTR_EN
    chk("te_ack", tmr_ack, 1);
    chk("te_ecall", ecall_trap_ena, 0);
    chk("te_mcause", trap_mcause_value,
        64'h8000_0000_0000_0007);
`else
    chk("te_ack", tmr_ack, 0);
    chk("te_ecall", ecall_trap_ena, 1);
`endif
    chk("te_wbck", ctl_wbck_data, 64'h100);
    cyc();
    idle();
    cyc();
    cyc();

    // timer on an ordinary instruction
    commit(64'h400, 0, 0, 1);
    @(negedge clk);
`ifdef TRAP_CTRL_TMR_INTR_EN
    chk("tm_ack", tmr_ack, 1);
    chk("tm_wbck", ctl_wbck_data, 64'h404);
`else
    chk("tm_ack", tmr_ack, 0);
    chk("tm_flush", flush, 0);
`endif
    cyc();
    idle();
    cyc();
    cyc();

    // stalled ecall waits for the stall to clear
    commit(64'h500, 1, 0, 0);
    ex_stall = 1'b1;
    @(negedge clk);
    chk("st_ecall0", ecall_trap_ena, 0);
    cyc();
    @(negedge clk);
    chk("st_busy", busy, 0);
    cyc();
    ex_stall = 1'b0;
    @(negedge clk);
    chk("st_ecall1", ecall_trap_ena, 1);
    chk("st_wbck", ctl_wbck_data, 64'h500);
    cyc();
    idle();
    cyc();
    cyc();

    // no commit -> no event; ecall beats mret
    cmt_ecall = 1'b1;
    @(negedge clk);
    chk("nv_flush", flush, 0);
    cyc();
    commit(64'h600, 1, 1, 0);
    @(negedge clk);
    chk("em_mret", cmt_mret_ena, 0);
    cyc();
    idle();
    cyc();
    cyc();

    // reset while waiting on fetch
    rif.redir_ready = 1'b0;
    commit(64'h700, 0, 1, 0);
    cyc();
    idle();
    cyc();
    @(negedge clk);
    chk("rw_valid0", rif.redir_valid, 1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rw_valid", rif.redir_valid, 0);
    chk("rw_busy", busy, 0);
    chk("rw_pc", rif.redir_pc, 0);
    cyc();
    rif.redir_ready = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
